// File: rtl/timer_pkg.sv
// Shared types for the loadable down-counting timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } timer_state_t;

endpackage

// File: rtl/down_timer_prescaler.sv
// Step-rate divider for down_timer: one step every presc+1 enabled cycles.
module prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] presc,
    output logic                  step
);

    logic [PRESCALE_W-1:0] r_pc;
    logic                  w_hit;

    // presc is live; if it drops below r_pc the counter wraps before matching
    assign w_hit = (r_pc == presc);
    assign step  = en && w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= '0;
        end else if (clr) begin
            r_pc <= '0;
        end else if (en) begin
            if (w_hit) begin
                r_pc <= '0;
            end else begin
                r_pc <= r_pc + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer with prescaler, hold and auto-reload.
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WIDTH-1:0]      v,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  hold,
    input  logic                  auto_reload,
    input  logic [PRESCALE_W-1:0] presc,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done
);

    timer_state_t r_state;
    timer_state_t w_state_nx;

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_done;

    logic [WIDTH-1:0] w_count_nx;
    logic [WIDTH-1:0] w_reload_nx;
    logic             w_done_nx;

    logic [WIDTH-1:0] w_eff_count;
    logic             w_start_req;
    logic             w_start_go;
    logic             w_start_zero;
    logic             w_en;
    logic             w_step;
    logic             w_clr;
    logic             w_last;

    // A same-cycle load makes start act on the new value
    assign w_eff_count  = load ? v : r_count;
    assign w_start_req  = !stop && start && (r_state == IDLE);
    assign w_start_go   = w_start_req && (w_eff_count != '0);
    assign w_start_zero = w_start_req && (w_eff_count == '0);

    assign w_en   = (r_state == RUN) && !hold;
    assign w_clr  = stop || load || w_start_go;
    assign w_last = (r_count == WIDTH'(1));

    prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (w_en),
        .presc (presc),
        .step  (w_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (stop) begin
            w_state_nx = IDLE;
        end else if (load) begin
            if (w_start_go) begin
                w_state_nx = RUN;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_start_go) begin
                        w_state_nx = RUN;
                    end
                end
                RUN: begin
                    if (hold) begin
                        w_state_nx = HOLD;
                    end else if (w_step && w_last && !auto_reload) begin
                        w_state_nx = IDLE;
                    end
                end
                HOLD: begin
                    if (!hold) begin
                        w_state_nx = RUN;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy = (r_state != IDLE);
    end

    always_comb begin
        w_count_nx  = r_count;
        w_reload_nx = r_reload;
        w_done_nx   = 1'b0;
        if (stop) begin
            w_count_nx = r_count;
        end else if (load) begin
            w_count_nx  = v;
            w_reload_nx = v;
            w_done_nx   = w_start_zero;
        end else if (w_start_zero) begin
            w_done_nx = 1'b1;
        end else if (w_step) begin
            // w_step already excludes hold; a zero count never wraps
            if (r_count > WIDTH'(1)) begin
                w_count_nx = r_count - WIDTH'(1);
            end else if (w_last) begin
                w_done_nx  = 1'b1;
                w_count_nx = auto_reload ? r_reload : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
        end else begin
            r_count  <= w_count_nx;
            r_reload <= w_reload_nx;
            r_done   <= w_done_nx;
        end
    end

    assign count = r_count;
    assign done  = r_done;

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: random and directed stimulus vs a rule model.
module tb_down_timer;

    localparam int W  = 8;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [W-1:0]  v = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          hold = 1'b0;
    logic          auto_reload = 1'b0;
    logic [PW-1:0] presc = '0;
    logic [W-1:0]  count;
    logic          busy;
    logic          done;

    down_timer #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst(rst), .load(load), .v(v),
        .start(start), .stop(stop), .hold(hold),
        .auto_reload(auto_reload), .presc(presc),
        .count(count), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] c;
        logic         b;
        logic         d;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    // Model: running flag, frozen flag, cycles elapsed within current step
    int m_cnt = 0, m_rel = 0, m_el = 0;
    bit m_run = 0, m_frz = 0, m_done = 0;

    task automatic model_edge();
        m_done = 0;
        if (rst) begin
            m_cnt = 0; m_rel = 0; m_el = 0; m_run = 0; m_frz = 0;
        end else if (stop) begin
            m_run = 0; m_frz = 0; m_el = 0;
        end else if (load) begin
            m_cnt = int'(v); m_rel = int'(v); m_el = 0;
            if (!m_run && start) begin
                if (v == 0) m_done = 1;
                else m_run = 1;
            end
        end else if (!m_run) begin
            if (start) begin
                if (m_cnt == 0) m_done = 1;
                else begin m_run = 1; m_el = 0; end
            end
        end else if (m_frz) begin
            if (!hold) m_frz = 0;
        end else if (hold) begin
            m_frz = 1;
        end else if (m_el == int'(presc)) begin
            m_el = 0;
            if (m_cnt > 1) m_cnt = m_cnt - 1;
            else if (m_cnt == 1) begin
                m_done = 1;
                if (auto_reload) m_cnt = m_rel;
                else begin m_cnt = 0; m_run = 0; end
            end
        end else begin
            m_el = (m_el + 1) % (1 << PW);
        end
    endtask

    task automatic tick();
        exp_t e;
        model_edge();
        e.c = W'(m_cnt);
        e.b = m_run;
        e.d = m_done;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            if (count !== mon_e.c || busy !== mon_e.b || done !== mon_e.d) begin
                errors++;
                $display("FAIL scoreboard t=%0t got count=%0d busy=%0b done=%0b want count=%0d busy=%0b done=%0b",
                         $time, count, busy, done, mon_e.c, mon_e.b, mon_e.d);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; load = 0; start = 0; stop = 0; hold = 0;
    endtask

    task automatic load_start(input int val, input int p, input bit ar);
        idle_inputs();
        presc = PW'(p); auto_reload = ar;
        load = 1; v = W'(val); tick();
        load = 0; start = 1; tick();
        start = 0;
    endtask

    task automatic run_done(input int maxc, output int n);
        n = -1;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (done === 1'b1) begin n = i; break; end
        end
    endtask

    int n;

    initial begin
        rst = 1;
        tick(); tick();
        check("reset_count", int'(count), 0);
        check("reset_busy", int'(busy), 0);
        idle_inputs();

        load_start(5, 0, 0);
        run_done(20, n);
        check("lat_v5_p0", n, 5);
        check("busy_after_done", int'(busy), 0);

        load_start(3, 2, 0);
        run_done(40, n);
        check("lat_v3_p2", n, 9);
        tick();
        check("done_width", int'(done), 0);

        load_start(4, 0, 1);
        for (int k = 0; k < 3; k++) begin
            run_done(20, n);
            check("ar_period", n, 4);
            check("ar_busy", int'(busy), 1);
            check("ar_reload", int'(count), 4);
        end
        stop = 1; tick(); idle_inputs(); auto_reload = 0;

        load_start(6, 0, 0);
        tick(); tick();
        check("pre_hold_count", int'(count), 4);
        hold = 1;
        repeat (5) tick();
        check("hold_count", int'(count), 4);
        check("hold_busy", int'(busy), 1);
        hold = 0; tick();
        run_done(20, n);
        check("post_hold_lat", n, 4);

        load_start(10, 0, 0);
        repeat (3) tick();
        stop = 1; tick(); stop = 0;
        check("stop_count", int'(count), 7);
        check("stop_busy", int'(busy), 0);
        check("stop_done", int'(done), 0);
        load = 1; start = 1; v = 0; tick(); idle_inputs();
        check("zero_start_done", int'(done), 1);
        check("zero_start_busy", int'(busy), 0);

        load_start(5, 0, 0);
        repeat (3) tick();
        rst = 1; load = 1; v = 9; tick(); idle_inputs();
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            load  = ($urandom_range(0, 24) == 0);
            start = ($urandom_range(0, 9) == 0);
            v     = W'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) hold = ~hold;
            if ($urandom_range(0, 49) == 0) presc = PW'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) auto_reload = ~auto_reload;
            tick();
        end
        idle_inputs();
        tick();

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
